// File: rtl/mmc_boot_ps_shifter_if.sv
// Byte-stream handshake between the MMC block-read datapath (master) and
// the Passive Serial shifter (slave). A byte transfers on a cycle where
// byte_valid and byte_ready are both high; byte_last marks the final byte.
//
// Signals:
//   byte_data   master->slave  bitstream byte
//   byte_valid  master->slave  byte_data is valid
//   byte_last   master->slave  byte_data is the final bitstream byte
//   byte_ready  slave->master  slave can accept a byte this cycle
interface mmc_boot_ps_shifter_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        output byte_last,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        input  byte_last,
        output byte_ready
    );
endinterface

// File: rtl/mmc_boot_ps_shifter.sv
// Passive Serial configuration driver for a Xilinx FPGA, fed by the MMC
// boot byte stream. Pulses PROG_B, waits for the INIT_B low/high handshake,
// shifts each byte MSB first on DIN against a divided CCLK, then keeps CCLK
// running until DONE rises plus a few extra cycles.
//
// Build option: define MMC_BOOT_PS_BYTECNT_EN to build the shifted-byte
// counter; without it o_byte_count is tied to zero.
//
// Ports:
//   sys_clk        in   system clock
//   rst_n          in   asynchronous reset, active low
//   i_start        in   one-cycle pulse, starts configuration when not busy
//   byte_if        slave modport of mmc_boot_ps_shifter_if (byte stream)
//   o_cclk         out  configuration clock (registered)
//   o_din          out  configuration data (registered)
//   o_prog_b       out  FPGA PROG_B, active low
//   i_init_b       in   FPGA INIT_B (asynchronous, 2-flop synchronised)
//   i_done         in   FPGA DONE (asynchronous, 2-flop synchronised)
//   o_busy         out  configuration in progress
//   o_cfg_done     out  configuration complete, held until next start
//   o_cfg_error    out  configuration failed, held until next start
//   o_byte_count   out  bytes fully shifted out (saturating)
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | after reset, waiting for start
// PROG       | PROG_B held low for PROG_CYCLES
// WAIT_INIT  | waiting for synced INIT_B to go low, then high
// SHIFT      | shifting bytes out MSB first; INIT_B low aborts (CRC)
// WAIT_DONE  | free-running CCLK with DIN=1 until DONE or timeout
// EXTRA      | DONE_EXTRA more CCLK rising edges
// FINISH     | configuration complete
// ERROR      | INIT_B fell during SHIFT, or DONE timed out
module mmc_boot_ps_shifter #(
    parameter int DIV          = 16,
    parameter int PROG_CYCLES  = 64,
    parameter int DONE_EXTRA   = 8,
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic                        sys_clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    mmc_boot_ps_shifter_if.slave        byte_if,
    output logic                        o_cclk,
    output logic                        o_din,
    output logic                        o_prog_b,
    input  logic                        i_init_b,
    input  logic                        i_done,
    output logic                        o_busy,
    output logic                        o_cfg_done,
    output logic                        o_cfg_error,
    output logic [23:0]                 o_byte_count
);

    localparam int PW    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int TMAX0 = (PROG_CYCLES > DONE_TIMEOUT) ? PROG_CYCLES : DONE_TIMEOUT;
    localparam int TMAX  = (TMAX0 > DONE_EXTRA) ? TMAX0 : DONE_EXTRA;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROG,
        ST_WAIT_INIT,
        ST_SHIFT,
        ST_WAIT_DONE,
        ST_EXTRA,
        ST_FINISH,
        ST_ERROR
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [PW-1:0]   r_phase;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_sh_last;
    logic            r_active;
    logic [7:0]      r_hold_data;
    logic            r_hold_last;
    logic            r_hold_full;
    logic            r_init_seen;
    logic            r_cclk;
    logic            r_din;
    logic            r_prog_b;
    logic            r_cfg_done;
    logic            r_cfg_error;
    logic            r_init_s1, r_init_s2;
    logic            r_done_s1, r_done_s2;

    logic            w_busy;
    logic            w_start_go;
    logic            w_phase_end;
    logic [PW-1:0]   w_phase_nxt;
    logic            w_cclk_nxt;
    logic            w_rise_nxt;
    logic            w_ready;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_s1 <= 1'b1;
            r_init_s2 <= 1'b1;
            r_done_s1 <= 1'b0;
            r_done_s2 <= 1'b0;
        end else begin
            r_init_s1 <= i_init_b;
            r_init_s2 <= r_init_s1;
            r_done_s1 <= i_done;
            r_done_s2 <= r_done_s1;
        end
    end

    assign w_busy      = !((r_state == ST_IDLE) || (r_state == ST_FINISH) || (r_state == ST_ERROR));
    assign w_start_go  = i_start && !w_busy;
    assign w_phase_end = (r_phase == PW'(DIV - 1));
    assign w_phase_nxt = w_phase_end ? '0 : (r_phase + PW'(1));
    assign w_cclk_nxt  = (w_phase_nxt >= PW'(DIV / 2));
    assign w_rise_nxt  = (w_phase_nxt == PW'(DIV / 2));
    assign w_ready     = (r_state == ST_SHIFT) && !r_hold_full;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_phase     <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_sh_last   <= 1'b0;
            r_active    <= 1'b0;
            r_hold_data <= '0;
            r_hold_last <= 1'b0;
            r_hold_full <= 1'b0;
            r_init_seen <= 1'b0;
            r_cclk      <= 1'b0;
            r_din       <= 1'b1;
            r_prog_b    <= 1'b1;
            r_cfg_done  <= 1'b0;
            r_cfg_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FINISH, ST_ERROR: begin
                    if (w_start_go) begin
                        r_state     <= ST_PROG;
                        r_timer     <= TW'(PROG_CYCLES - 1);
                        r_prog_b    <= 1'b0;
                        r_cfg_done  <= 1'b0;
                        r_cfg_error <= 1'b0;
                        r_hold_full <= 1'b0;
                        r_init_seen <= 1'b0;
                        r_active    <= 1'b0;
                        r_phase     <= '0;
                        r_cclk      <= 1'b0;
                        r_din       <= 1'b1;
                    end
                end

                ST_PROG: begin
                    if (r_timer == '0) begin
                        r_prog_b <= 1'b1;
                        r_state  <= ST_WAIT_INIT;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end

                ST_WAIT_INIT: begin
                    if (!r_init_s2) begin
                        r_init_seen <= 1'b1;
                    end else if (r_init_seen) begin
                        r_state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // INIT_B low here is a CRC error and wins over any byte boundary.
                    if (!r_init_s2) begin
                        r_state     <= ST_ERROR;
                        r_cfg_error <= 1'b1;
                        r_cclk      <= 1'b0;
                        r_din       <= 1'b1;
                        r_active    <= 1'b0;
                        r_phase     <= '0;
                        r_hold_full <= 1'b0;
                    end else begin
                        if (w_ready && byte_if.byte_valid) begin
                            r_hold_data <= byte_if.byte_data;
                            r_hold_last <= byte_if.byte_last;
                            r_hold_full <= 1'b1;
                        end
                        if (!r_active || w_phase_end) begin
                            if (r_active && (r_bit != 3'd0)) begin
                                r_bit   <= r_bit - 3'd1;
                                r_phase <= '0;
                                r_cclk  <= 1'b0;
                                r_din   <= r_shift[r_bit - 3'd1];
                            end else if (r_active && r_sh_last) begin
                                r_state  <= ST_WAIT_DONE;
                                r_timer  <= TW'(DONE_TIMEOUT - 1);
                                r_active <= 1'b0;
                                r_phase  <= '0;
                                r_cclk   <= 1'b0;
                                r_din    <= 1'b1;
                            end else if (r_hold_full) begin
                                // Byte boundary: take the held byte and free the register now.
                                r_shift     <= r_hold_data;
                                r_sh_last   <= r_hold_last;
                                r_bit       <= 3'd7;
                                r_active    <= 1'b1;
                                r_phase     <= '0;
                                r_cclk      <= 1'b0;
                                r_din       <= r_hold_data[7];
                                r_hold_full <= 1'b0;
                            end else begin
                                // Underrun: park CCLK low, keep DIN.
                                r_active <= 1'b0;
                                r_phase  <= '0;
                                r_cclk   <= 1'b0;
                            end
                        end else begin
                            r_phase <= w_phase_nxt;
                            r_cclk  <= w_cclk_nxt;
                        end
                    end
                end

                ST_WAIT_DONE: begin
                    r_phase <= w_phase_nxt;
                    r_cclk  <= w_cclk_nxt;
                    r_din   <= 1'b1;
                    if (r_done_s2) begin
                        r_state <= ST_EXTRA;
                        r_timer <= TW'(DONE_EXTRA);
                    end else if (w_phase_end) begin
                        if (r_timer == '0) begin
                            r_state     <= ST_ERROR;
                            r_cfg_error <= 1'b1;
                            r_phase     <= '0;
                            r_cclk      <= 1'b0;
                        end else begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                end

                ST_EXTRA: begin
                    // Timer counts rising edges still owed; finish at the end of
                    // the high half of the last one so no runt pulse is left.
                    r_phase <= w_phase_nxt;
                    r_cclk  <= w_cclk_nxt;
                    r_din   <= 1'b1;
                    if (w_rise_nxt && (r_timer != '0)) begin
                        r_timer <= r_timer - TW'(1);
                    end
                    if (w_phase_end && (r_timer == '0)) begin
                        r_state    <= ST_FINISH;
                        r_cfg_done <= 1'b1;
                        r_phase    <= '0;
                        r_cclk     <= 1'b0;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MMC_BOOT_PS_BYTECNT_EN
    logic [23:0] r_byte_count;
    logic        w_byte_done;

    assign w_byte_done = (r_state == ST_SHIFT) && r_init_s2 && r_active &&
                         w_phase_end && (r_bit == 3'd0);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_count <= '0;
        end else if (w_start_go) begin
            r_byte_count <= '0;
        end else if (w_byte_done && (r_byte_count != 24'hFFFFFF)) begin
            r_byte_count <= r_byte_count + 24'd1;
        end
    end

    assign o_byte_count = r_byte_count;
`else
    assign o_byte_count = '0;
`endif

    assign byte_if.byte_ready = w_ready;
    assign o_cclk             = r_cclk;
    assign o_din              = r_din;
    assign o_prog_b           = r_prog_b;
    assign o_busy             = w_busy;
    assign o_cfg_done         = r_cfg_done;
    assign o_cfg_error        = r_cfg_error;

endmodule

// File: tb/tb_mmc_boot_ps_shifter.sv
// Bench for mmc_boot_ps_shifter: random byte streams checked against a
// queue-based model of the serial bit stream and CCLK timing.
module tb_mmc_boot_ps_shifter;

    localparam int DIV   = 4;
    localparam int PROG  = 8;
    localparam int EXTRA = 8;
    localparam int TMO   = 16;
`ifdef MMC_BOOT_PS_BYTECNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic        init_b  = 1'b1;
    logic        done    = 1'b0;
    logic        cclk, din, prog_b, busy, cfg_done, cfg_error;
    logic [23:0] byte_count;

    mmc_boot_ps_shifter_if bif ();

    mmc_boot_ps_shifter #(
        .DIV(DIV), .PROG_CYCLES(PROG), .DONE_EXTRA(EXTRA), .DONE_TIMEOUT(TMO)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .i_start(start), .byte_if(bif),
        .o_cclk(cclk), .o_din(din), .o_prog_b(prog_b),
        .i_init_b(init_b), .i_done(done), .o_busy(busy),
        .o_cfg_done(cfg_done), .o_cfg_error(cfg_error), .o_byte_count(byte_count)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // cclk edge monitor, sampled 1 time unit after each sys_clk rise
    logic prev_cclk = 1'b0;
    int   cyc       = 0;
    int   rise_cnt  = 0;
    logic rise_din[$];
    int   rise_cyc[$];

    always @(posedge sys_clk) begin
        #1;
        if (cclk === 1'b1 && prev_cclk === 1'b0) begin
            rise_din.push_back(din);
            rise_cyc.push_back(cyc);
            rise_cnt++;
        end
        prev_cclk = cclk;
        cyc++;
    end

    logic [23:0] model_cnt;

    function automatic logic [31:0] exp_cnt();
        return CNT_EN ? 32'(model_cnt) : 32'd0;
    endfunction

    task automatic clr_mon();
        rise_cnt = 0;
        rise_din.delete();
        rise_cyc.delete();
    endtask

    task automatic wait_rises(input int target, input int budget, input string tag);
        int k = 0;
        while (rise_cnt < target && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        if (rise_cnt < target) chk({tag, "_tmo"}, 32'(rise_cnt), 32'(target));
    endtask

    task automatic do_start();
        int n = 0;
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        model_cnt = '0;
        chk("start_clr_err", 32'(cfg_error), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        while (prog_b == 1'b0 && n < 100) begin
            n++;
            @(negedge sys_clk);
        end
        chk("prog_low_cycles", 32'(n), 32'(PROG));
    endtask

    task automatic init_pulse();
        logic seen = 1'b0;
        int   k    = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (bif.byte_ready !== 1'b0) seen = 1'b1;
        end
        init_b = 1'b0;
        repeat (4) begin
            @(negedge sys_clk);
            if (bif.byte_ready !== 1'b0) seen = 1'b1;
        end
        init_b = 1'b1;
        chk("ready_pre_init", 32'(seen), 32'd0);
        while (bif.byte_ready !== 1'b1 && k < 20) begin
            @(negedge sys_clk);
            k++;
        end
        chk("ready_after_init", 32'(bif.byte_ready), 32'd1);
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic push_byte(input logic [7:0] d, input logic l);
        int k = 0;
        bif.byte_data  = d;
        bif.byte_last  = l;
        bif.byte_valid = 1'b1;
        while (bif.byte_ready !== 1'b1 && k < 2000) begin
            @(negedge sys_clk);
            k++;
        end
        if (k >= 2000) chk("push_tmo", 32'(k), 32'd0);
        @(negedge sys_clk);
        bif.byte_valid = 1'b0;
    endtask

    // Rebuild bytes from din at each cclk rise and check period spacing.
    task automatic check_bytes(input logic [7:0] exp_q[$], input int gap_at);
        int badi = 0;
        for (int b = 0; b < exp_q.size(); b++) begin
            logic [7:0] got = '0;
            for (int j = 0; j < 8; j++) got = {got[6:0], rise_din[8*b + j]};
            chk("byte_bits", 32'(got), 32'(exp_q[b]));
        end
        for (int i = 1; i < 8 * exp_q.size(); i++) begin
            int d = rise_cyc[i] - rise_cyc[i-1];
            if (i == gap_at) begin
                if (d <= DIV) badi++;
            end else if (d != DIV) begin
                badi++;
            end
        end
        chk("cclk_period", 32'(badi), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cclk"}, 32'(cclk), 32'd0);
        chk({tag, "_din"}, 32'(din), 32'd1);
        chk({tag, "_prog_b"}, 32'(prog_b), 32'd1);
        chk({tag, "_ready"}, 32'(bif.byte_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(cfg_done), 32'd0);
        chk({tag, "_err"}, 32'(cfg_error), 32'd0);
        chk({tag, "_cnt"}, 32'(byte_count), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        int         base, k, gap, n;
        logic       ok, d0, bad_wd;

        bif.byte_data  = '0;
        bif.byte_valid = 1'b0;
        bif.byte_last  = 1'b0;
        model_cnt      = '0;
        repeat (3) @(negedge sys_clk);
        chk_reset_vals("rst_in");
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk_reset_vals("rst_out");

        // Fixed stream A5, 3C with valid held; then DONE after 5 CCLKs.
        do_start();
        init_pulse();
        clr_mon();
        push_byte(8'hA5, 1'b0);
        push_byte(8'h3C, 1'b1);
        wait_rises(16, 400, "stream1");
        q = {8'hA5, 8'h3C};
        model_cnt = 24'd2;
        check_bytes(q, -1);
        wait_rises(21, 200, "wd5");
        done = 1'b1;
        base = rise_cnt;
        k = 0;
        while (cfg_done !== 1'b1 && k < 300) begin
            @(negedge sys_clk);
            k++;
        end
        chk("extra_rises", 32'(rise_cnt - base), 32'(EXTRA));
        chk("fin_done", 32'(cfg_done), 32'd1);
        chk("fin_busy", 32'(busy), 32'd0);
        chk("fin_cclk", 32'(cclk), 32'd0);
        chk("fin_cnt", 32'(byte_count), exp_cnt());
        bad_wd = 1'b0;
        for (int i = 16; i < rise_din.size(); i++) if (rise_din[i] !== 1'b1) bad_wd = 1'b1;
        chk("wd_din_high", 32'(bad_wd), 32'd0);
        done = 1'b0;

        // Random bytes with an underrun gap, then DONE timeout.
        do_start();
        init_pulse();
        clr_mon();
        q.delete();
        for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
        gap = $urandom_range(20, 30);
        push_byte(q[0], 1'b0);
        wait_rises(8, 200, "gap_b0");
        repeat (DIV / 2) @(negedge sys_clk);
        d0 = din;
        ok = 1'b1;
        repeat (gap) begin
            @(negedge sys_clk);
            if (cclk !== 1'b0 || din !== d0) ok = 1'b0;
        end
        chk("gap_stable", 32'(ok), 32'd1);
        chk("gap_no_edge", 32'(rise_cnt), 32'd8);
        push_byte(q[1], 1'b0);
        push_byte(q[2], 1'b1);
        wait_rises(24, 400, "stream2");
        model_cnt = 24'd3;
        check_bytes(q, 8);
        k = 0;
        while (cfg_error !== 1'b1 && k < 500) begin
            @(negedge sys_clk);
            k++;
        end
        chk("tmo_rises", 32'(rise_cnt - 24), 32'(TMO));
        chk("tmo_err", 32'(cfg_error), 32'd1);
        chk("tmo_cclk", 32'(cclk), 32'd0);
        chk("tmo_din", 32'(din), 32'd1);
        chk("tmo_prog_b", 32'(prog_b), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_cnt", 32'(byte_count), exp_cnt());

        // INIT_B falls in the middle of byte 1.
        do_start();
        init_pulse();
        clr_mon();
        push_byte(8'($urandom), 1'b0);
        push_byte(8'($urandom), 1'b0);
        wait_rises(8 + $urandom_range(1, 6), 400, "crc_mid");
        init_b = 1'b0;
        n = 0;
        while (cfg_error !== 1'b1 && n < 10) begin
            @(negedge sys_clk);
            n++;
        end
        model_cnt = 24'd1;
        chk("crc_latency_le3", 32'(n <= 3), 32'd1);
        chk("crc_cclk", 32'(cclk), 32'd0);
        chk("crc_din", 32'(din), 32'd1);
        chk("crc_busy", 32'(busy), 32'd0);
        chk("crc_cnt", 32'(byte_count), exp_cnt());
        @(negedge sys_clk);
        init_b = 1'b1;

        // Asynchronous reset in the middle of SHIFT.
        do_start();
        init_pulse();
        clr_mon();
        push_byte(8'($urandom), 1'b0);
        wait_rises(3, 200, "rst_mid");
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmc_boot_ps_shifter.md
Name: mmc_boot_ps_shifter

Overview:
- Consumer end of the MMC boot path: drives a Xilinx FPGA in Passive Serial mode from bitstream bytes read off the MMC card.
- Sequences PROG_B/INIT_B, shifts each byte MSB first on DIN with a divided CCLK, then clocks until DONE.
- Sits between the MMC block-read datapath (byte stream) and the target FPGA configuration pins.

Parameters:
- DIV, 16: sys_clk cycles per CCLK period; even, >=2.
- PROG_CYCLES, 64: sys_clk cycles PROG_B is held low.
- DONE_EXTRA, 8: CCLK cycles issued after DONE is seen high.
- DONE_TIMEOUT, 1024: CCLK cycles allowed for DONE after the last bit before error.

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- start  in  1  one-cycle pulse; begins configuration from IDLE/FINISH/ERROR
- byte_data  in  8  bitstream byte
- byte_valid  in  1  byte_data valid
- byte_last  in  1  qualifies byte_data as the final byte
- byte_ready  out  1  holding register empty; transfer on valid&ready
- cclk  out  1  configuration clock, registered
- din  out  1  configuration data, registered
- prog_b  out  1  FPGA PROG_B, active low
- init_b  in  1  FPGA INIT_B; synchronised with 2 flops internally
- done  in  1  FPGA DONE; synchronised with 2 flops internally
- busy  out  1  high in any state except IDLE/FINISH/ERROR
- cfg_done  out  1  configuration complete, held until next start
- cfg_error  out  1  configuration failed, held until next start
- byte_count  out  24  bytes shifted out (see Optional Feature)

Behaviour:
- Reset values: cclk=0, din=1, prog_b=1, byte_ready=0, busy=0, cfg_done=0, cfg_error=0, byte_count=0. State=IDLE. rst_n low mid-operation aborts immediately to these values.
- States: IDLE, PROG, WAIT_INIT, SHIFT, WAIT_DONE, EXTRA, FINISH, ERROR.
- IDLE/FINISH/ERROR + start -> PROG.
  - On entry, clear cfg_done, cfg_error, byte_count, holding register, and prog_b=0 for PROG_CYCLES cycles.
- PROG -> WAIT_INIT with prog_b=1.
- WAIT_INIT: wait for synced init_b low then high. Then -> SHIFT. No timeout.
- Holding register: byte_ready=1 when empty in SHIFT only.
  - valid&ready loads data+last; byte_ready drops the next cycle.
  - The shifter takes the byte at a bit-0 boundary, freeing the register in the same cycle, so streaming needs no gaps.
- CCLK generation: phase counter 0..DIV-1 runs only while a bit is being sent.
  - cclk=0 for phase<DIV/2, 1 otherwise.
  - din is updated when phase=0, i.e. one full low half before the rising edge.
  - 8 CCLK periods per byte, MSB (bit 7) first.
- Underrun: no byte available at a byte boundary -> cclk parks low, phase holds at 0, din holds its last value, and no spurious edge occurs.
- SHIFT, synced init_b low at any time -> ERROR (CRC error). Takes priority over the same-cycle byte boundary.
- After bit 0 of a byte with last=1 completes its high half -> WAIT_DONE.
- WAIT_DONE: free-running CCLK with din=1.
  - Synced done high -> EXTRA.
  - DONE_TIMEOUT CCLK periods without done -> ERROR.
- EXTRA: DONE_EXTRA further CCLK periods, then -> FINISH with cfg_done=1.
- ERROR: cfg_error=1, cclk=0, din=1, prog_b=1.
- start while busy is ignored.
- byte_valid outside SHIFT is ignored (byte_ready=0).
- byte_count increments when a byte's bit 0 completes.
  - Saturates at 24'hFFFFFF with no wrap.

Optional Feature:
- Macro MMC_BOOT_PS_BYTECNT_EN.
- Defined: byte_count is live as described above.
- Undefined: the counter is not built and byte_count is tied to 0.
- All other behaviour is identical in both cases.

Test Plan:
- Reset then start with DIV=4, PROG_CYCLES=8 -> prog_b low exactly 8 cycles; byte_ready stays 0 until init_b pulses low then high.
- Stream bytes 0xA5 then 0x3C with byte_last on 0x3C, valid held high -> din sampled on cclk rising = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0, each cclk period 4 cycles, no gaps; byte_count=2.
- Insert a 20-cycle valid gap between bytes -> cclk stays 0 during the gap, din is stable, and the bit sequence is still correct.
- After the last byte, raise done after 5 CCLKs with DONE_EXTRA=8 -> exactly 8 more cclk rising edges, then cfg_done=1 and busy=0.
- Pull init_b low in the middle of byte 1 -> cfg_error=1 within 3 cycles (sync), cclk=0; a subsequent start clears cfg_error and re-pulses prog_b.
- done never rises with DONE_TIMEOUT=16 -> cfg_error after 16 CCLK periods; rst_n asserted mid-SHIFT -> all outputs return to reset values asynchronously.
